// File: rtl/rr_port_arbiter.sv
// Four-port round-robin arbiter with registered one-hot grant, mux select,
// per-grant timeout and a sticky identifier of the last revoked requester.
module rr_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout_err,
    output logic [1:0] err_id
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        r_state;
    logic [1:0]    r_ptr;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_gnt;
    logic [1:0]    r_sel;
    logic          r_busy;
    logic          r_toErr;
    logic [1:0]    r_errId;

    logic          w_atLimit;
    logic          w_release;
    logic          w_timeout;
    logic [1:0]    w_basePtr;
    logic [1:0]    w_scanIdx;
    logic [1:0]    w_winSel;
    logic          w_winFound;
    logic [3:0]    w_winGnt;
    logic [CW-1:0] w_cntNext;

    // A grant ends on done, on the holder dropping its request, or on expiry;
    // only expiry with the holder still asking and no done counts as an error.
    always_comb begin
        w_atLimit = (r_cnt == CW'(TIMEOUT - 1));
        w_release = (r_state == GRANT) && (done || !req[r_sel] || w_atLimit);
        w_timeout = (r_state == GRANT) && !done && req[r_sel] && w_atLimit;
        w_cntNext = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
    end

    // Scan starts one past the pointer; on a release the pointer moves to the
    // releasing holder in the same cycle so the next winner is chosen fairly.
    always_comb begin
        w_basePtr  = w_release ? r_sel : r_ptr;
        w_scanIdx  = 2'd0;
        w_winSel   = 2'd0;
        w_winFound = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_scanIdx = w_basePtr + 2'(k);
            if (!w_winFound && req[w_scanIdx]) begin
                w_winSel   = w_scanIdx;
                w_winFound = 1'b1;
            end
        end
        w_winGnt = 4'b0001 << w_winSel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= 2'd3;
            r_cnt   <= '0;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_busy  <= 1'b0;
            r_toErr <= 1'b0;
            r_errId <= 2'd0;
        end else begin
            r_toErr <= w_timeout;
            if (w_timeout) begin
                r_errId <= r_sel;
            end
            case (r_state)
                IDLE: begin
                    if (w_winFound) begin
                        r_state <= GRANT;
                        r_gnt   <= w_winGnt;
                        r_sel   <= w_winSel;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_ptr <= r_sel;
                        if (w_winFound) begin
                            r_gnt  <= w_winGnt;
                            r_sel  <= w_winSel;
                            r_busy <= 1'b1;
                            r_cnt  <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= 4'b0000;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= w_cntNext;
                    end
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign sel         = r_sel;
    assign busy        = r_busy;
    assign timeout_err = r_toErr;
    assign err_id      = r_errId;

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Scoreboard bench for rr_port_arbiter: directed vectors push hand-computed
// post-edge outputs; an independent monitor pops and compares each cycle.
module tb_rr_port_arbiter;

    typedef struct {
        int         idx;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       err;
        logic [1:0] errId;
    } expect_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout_err;
    logic [1:0] err_id;

    expect_t expectQueue[$];
    int      checkCount = 0;
    int      errorCount = 0;
    int      vecIdx = 0;

    rr_port_arbiter #(.TIMEOUT(4), .CW(8)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .done(done),
        .gnt(gnt),
        .sel(sel),
        .busy(busy),
        .timeout_err(timeout_err),
        .err_id(err_id)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [3:0] act, input logic [3:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        checkValue($sformatf("v%0d gnt", e.idx), gnt, e.gnt);
        checkValue($sformatf("v%0d sel", e.idx), {2'b00, sel}, {2'b00, e.sel});
        checkValue($sformatf("v%0d busy", e.idx), {3'b000, busy}, {3'b000, e.busy});
        checkValue($sformatf("v%0d timeout_err", e.idx), {3'b000, timeout_err}, {3'b000, e.err});
        checkValue($sformatf("v%0d err_id", e.idx), {2'b00, err_id}, {2'b00, e.errId});
    endtask

    // Drive one cycle of inputs and record what the outputs must be after the next edge.
    task automatic applyStimulus(input logic [3:0] reqIn, input logic doneIn,
                                 input logic [3:0] eGnt, input logic [1:0] eSel,
                                 input logic eBusy, input logic eErr, input logic [1:0] eId);
        expect_t e;
        @(posedge clk);
        #2;
        req  = reqIn;
        done = doneIn;
        e.idx   = vecIdx;
        e.gnt   = eGnt;
        e.sel   = eSel;
        e.busy  = eBusy;
        e.err   = eErr;
        e.errId = eId;
        expectQueue.push_back(e);
        vecIdx++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expectQueue.size() != 0) begin
                checkOutput(expectQueue.pop_front());
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        checkValue("reset gnt", gnt, 4'b0000);
        checkValue("reset sel", {2'b00, sel}, 4'd0);
        checkValue("reset busy", {3'b000, busy}, 4'd0);
        checkValue("reset timeout_err", {3'b000, timeout_err}, 4'd0);
        checkValue("reset err_id", {2'b00, err_id}, 4'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // All four requesting, done every third cycle: rotation 0,1,2,3,0.
        applyStimulus(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);

        // Single requester 2; done in IDLE is ignored and sel holds.
        applyStimulus(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 2'd0);
        applyStimulus(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 2'd0);

        // Requester 1 never completes: revoked after four grant cycles, then regranted afresh.
        applyStimulus(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 2'd1);
        applyStimulus(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd1);
        applyStimulus(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd1);
        applyStimulus(4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 2'd1);

        // done coincides with the last allowed cycle: normal handover 0 -> 1.
        applyStimulus(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd1);
        applyStimulus(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd1);
        applyStimulus(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd1);
        applyStimulus(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd1);
        applyStimulus(4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd1);
        applyStimulus(4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 2'd1);

        // Holder 2 ignores other req changes, then drops with 1 and 3 pending.
        applyStimulus(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd1);
        applyStimulus(4'b1110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd1);
        applyStimulus(4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 2'd1);
        applyStimulus(4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 2'd1);

        // Asynchronous reset in the middle of a grant.
        applyStimulus(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd1);
        applyStimulus(4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
        #2 rst = 1'b1;
        #1;
        checkValue("async rst gnt", gnt, 4'b0000);
        checkValue("async rst sel", {2'b00, sel}, 4'd0);
        checkValue("async rst busy", {3'b000, busy}, 4'd0);
        checkValue("async rst err_id", {2'b00, err_id}, 4'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        applyStimulus(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 2'd0);

        for (int i = 0; i < 10 && expectQueue.size() != 0; i++) begin
            @(posedge clk);
        end
        #2;
        checkValue("scoreboard drained", 4'(expectQueue.size()), 4'd0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
